// File: rtl/vga_timing_gen_if.sv
// Bundle of pixel-enable/run inputs and raster outputs of the timing generator.
// The master side drives CE/EN; the slave side is the generator itself.
interface vga_timing_gen_if #(
  parameter int unsigned CW  = 12,
  parameter int unsigned FCW = 16
);
  logic           i_PIX_CE;
  logic           i_EN;
  logic           o_HSYNC;
  logic           o_VSYNC;
  logic           o_DE;
  logic           o_HBLANK;
  logic           o_VBLANK;
  logic [CW-1:0]  o_X_COORD;
  logic [CW-1:0]  o_Y_COORD;
  logic           o_LINE_START;
  logic           o_FRAME_START;
  logic [FCW-1:0] o_FRAME_CNT;
  logic           o_RUNNING;

  modport master (
    output i_PIX_CE, i_EN,
    input  o_HSYNC, o_VSYNC, o_DE, o_HBLANK, o_VBLANK, o_X_COORD, o_Y_COORD,
           o_LINE_START, o_FRAME_START, o_FRAME_CNT, o_RUNNING
  );

  modport slave (
    input  i_PIX_CE, i_EN,
    output o_HSYNC, o_VSYNC, o_DE, o_HBLANK, o_VBLANK, o_X_COORD, o_Y_COORD,
           o_LINE_START, o_FRAME_START, o_FRAME_CNT, o_RUNNING
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with pixel clock-enable and run/stop control.
// Every output is registered from the next raster position, so syncs, DE and coords never skew.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int unsigned CW         = 12,
  parameter int unsigned FCW        = 16
) (
  input logic              i_CLK,
  input logic              i_RST,
  vga_timing_gen_if.slave  bus_io
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (64'(H_TOTAL) > (64'd1 << CW)) begin : g_h_total_chk
    $error("H_TOTAL does not fit in CW bits");
  end
  if (64'(V_TOTAL) > (64'd1 << CW)) begin : g_v_total_chk
    $error("V_TOTAL does not fit in CW bits");
  end

  localparam logic [CW-1:0] HActive    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] VActive    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HLast      = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] VLast      = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HSyncStart = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HSyncEnd   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VSyncStart = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VSyncEnd   = CW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  h_q, h_d, v_q, v_d;
  logic [FCW-1:0] cnt_q, cnt_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic hblank_q, hblank_d, vblank_q, vblank_d;
  logic line_start_q, line_start_d, frame_start_q, frame_start_d;

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    cnt_d   = cnt_q;
    if (bus_io.i_PIX_CE) begin
      unique case (state_q)
        StIdle: begin
          if (bus_io.i_EN) begin
            state_d = StRun;
            h_d     = '0;
            v_d     = '0;
          end
        end
        StRun: begin
          if (h_q != HLast) begin
            h_d = h_q + 1'b1;
          end else if (v_q != VLast) begin
            h_d = '0;
            v_d = v_q + 1'b1;
          end else if (bus_io.i_EN) begin
            h_d   = '0;
            v_d   = '0;
            cnt_d = cnt_q + 1'b1;
          end else begin
            // Stop at the frame end; coordinates keep the last position.
            state_d = StIdle;
          end
        end
      endcase
    end

    // Outputs decode the next position, so a held CE holds every output.
    hsync_d       = ~H_SYNC_POL;
    vsync_d       = ~V_SYNC_POL;
    de_d          = 1'b0;
    hblank_d      = 1'b1;
    vblank_d      = 1'b1;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (state_d == StRun) begin
      hsync_d       = (h_d >= HSyncStart && h_d < HSyncEnd) ? H_SYNC_POL : ~H_SYNC_POL;
      vsync_d       = (v_d >= VSyncStart && v_d < VSyncEnd) ? V_SYNC_POL : ~V_SYNC_POL;
      hblank_d      = (h_d >= HActive);
      vblank_d      = (v_d >= VActive);
      de_d          = !hblank_d && !vblank_d;
      line_start_d  = (h_d == '0);
      frame_start_d = (h_d == '0) && (v_d == '0);
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q       <= StIdle;
      h_q           <= '0;
      v_q           <= '0;
      cnt_q         <= '0;
      hsync_q       <= ~H_SYNC_POL;
      vsync_q       <= ~V_SYNC_POL;
      de_q          <= 1'b0;
      hblank_q      <= 1'b1;
      vblank_q      <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_q           <= h_d;
      v_q           <= v_d;
      cnt_q         <= cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus_io.o_HSYNC       = hsync_q;
  assign bus_io.o_VSYNC       = vsync_q;
  assign bus_io.o_DE          = de_q;
  assign bus_io.o_HBLANK      = hblank_q;
  assign bus_io.o_VBLANK      = vblank_q;
  assign bus_io.o_X_COORD     = h_q;
  assign bus_io.o_Y_COORD     = v_q;
  assign bus_io.o_LINE_START  = line_start_q;
  assign bus_io.o_FRAME_START = frame_start_q;
  assign bus_io.o_FRAME_CNT   = cnt_q;
  assign bus_io.o_RUNNING     = (state_q == StRun);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: two small-raster instances (active-low and active-high syncs) stepped
// through start, full frames, sparse CE, stop, restart, mid-frame reset and counter wrap.
module tb_vga_timing_gen;

  // Instance A: H 8/2/3/2 (total 15), V 4/1/2/1 (total 8), active-low syncs, 3-bit frame count.
  localparam int AHT = 15;
  localparam int AVT = 8;
  // Instance B: H 6/1/2/1 (total 10), V 3/1/1/1 (total 6), active-high syncs.
  localparam int BHT = 10;
  localparam int BVT = 6;

  logic clk;
  logic rst_a, rst_b;
  int   n_checks = 0;
  int   n_err    = 0;

  int mh, mv, mcnt;
  bit mrun;

  vga_timing_gen_if #(.CW(6), .FCW(3)) a_if ();
  vga_timing_gen_if #(.CW(4), .FCW(4)) b_if ();

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .CW(6), .FCW(3)
  ) u_a (
    .i_CLK  (clk),
    .i_RST  (rst_a),
    .bus_io (a_if.slave)
  );

  vga_timing_gen #(
    .H_ACTIVE(6), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CW(4), .FCW(4)
  ) u_b (
    .i_CLK  (clk),
    .i_RST  (rst_b),
    .bus_io (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // {hsync, vsync, de, hblank, vblank, line_start, frame_start}
  function automatic logic [6:0] exp_flags(input int h, input int v, input bit run,
                                           input int ha, input int hfp, input int hs,
                                           input int va, input int vfp, input int vs,
                                           input bit pol);
    logic hsy, vsy;
    if (!run) return {~pol, ~pol, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    hsy = (h >= ha + hfp && h < ha + hfp + hs) ? pol : ~pol;
    vsy = (v >= va + vfp && v < va + vfp + vs) ? pol : ~pol;
    return {hsy, vsy, (h < ha && v < va), (h >= ha), (v >= va), (h == 0), (h == 0 && v == 0)};
  endfunction

  function automatic logic [6:0] a_flags();
    return {a_if.o_HSYNC, a_if.o_VSYNC, a_if.o_DE, a_if.o_HBLANK, a_if.o_VBLANK,
            a_if.o_LINE_START, a_if.o_FRAME_START};
  endfunction

  function automatic logic [6:0] b_flags();
    return {b_if.o_HSYNC, b_if.o_VSYNC, b_if.o_DE, b_if.o_HBLANK, b_if.o_VBLANK,
            b_if.o_LINE_START, b_if.o_FRAME_START};
  endfunction

  task automatic model_a(input bit ce, input bit en);
    if (rst_a) begin
      mh = 0; mv = 0; mcnt = 0; mrun = 1'b0;
    end else if (ce) begin
      if (!mrun) begin
        if (en) begin mrun = 1'b1; mh = 0; mv = 0; end
      end else if (mh != AHT - 1) begin
        mh++;
      end else if (mv != AVT - 1) begin
        mh = 0; mv++;
      end else if (en) begin
        mh = 0; mv = 0; mcnt = (mcnt + 1) % 8;
      end else begin
        mrun = 1'b0;
      end
    end
  endtask

  task automatic step_a(input bit ce, input bit en);
    a_if.i_PIX_CE = ce;
    a_if.i_EN     = en;
    @(posedge clk);
    model_a(ce, en);
    #1;
    chk("a_x", 32'(a_if.o_X_COORD), 32'(mh));
    chk("a_y", 32'(a_if.o_Y_COORD), 32'(mv));
    chk("a_frame_cnt", 32'(a_if.o_FRAME_CNT), 32'(mcnt));
    chk("a_running", 32'(a_if.o_RUNNING), 32'(mrun));
    chk("a_flags", 32'(a_flags()), 32'(exp_flags(mh, mv, mrun, 8, 2, 3, 4, 1, 2, 1'b0)));
  endtask

  task automatic step_b();
    b_if.i_PIX_CE = 1'b1;
    b_if.i_EN     = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int de_cnt, hs_low, vs_low, hs_high, vs_high, h, v;
    rst_a = 1'b1;
    rst_b = 1'b1;
    a_if.i_PIX_CE = 1'b0;
    a_if.i_EN     = 1'b0;
    b_if.i_PIX_CE = 1'b0;
    b_if.i_EN     = 1'b0;

    // Reset state (CE=0: reset still takes effect).
    step_a(1'b0, 1'b0);
    chk("rst_flags", 32'(a_flags()), 32'(7'b1101100));
    chk("rst_running", 32'(a_if.o_RUNNING), 32'd0);

    // Start: first CE gives (0,0) with FRAME_START.
    rst_a = 1'b0;
    step_a(1'b1, 1'b1);
    chk("start_frame_start", 32'(a_if.o_FRAME_START), 32'd1);
    chk("start_x", 32'(a_if.o_X_COORD), 32'd0);
    de_cnt = 0; hs_low = 0; vs_low = 0;
    for (int i = 0; i < AHT * AVT; i++) begin
      if (i != 0) step_a(1'b1, 1'b1);
      if (a_if.o_DE) de_cnt++;
      if (!a_if.o_HSYNC) hs_low++;
      if (!a_if.o_VSYNC) vs_low++;
      if (a_if.o_X_COORD == 6'd10) chk("hsync_first_low", 32'(a_if.o_HSYNC), 32'd0);
      if (a_if.o_X_COORD == 6'd13) chk("hsync_after_end", 32'(a_if.o_HSYNC), 32'd1);
    end
    chk("de_per_frame", 32'(de_cnt), 32'd32);
    chk("hsync_low_per_frame", 32'(hs_low), 32'd24);
    chk("vsync_low_per_frame", 32'(vs_low), 32'd30);
    chk("frame_end_x", 32'(a_if.o_X_COORD), 32'd14);
    chk("frame_end_y", 32'(a_if.o_Y_COORD), 32'd7);

    // Wrap into frame 2.
    step_a(1'b1, 1'b1);
    chk("wrap_frame_start", 32'(a_if.o_FRAME_START), 32'd1);
    chk("wrap_frame_cnt", 32'(a_if.o_FRAME_CNT), 32'd1);

    // CE one cycle in four: every output held for the three idle clocks.
    for (int i = 0; i < 20; i++) begin
      step_a(1'b0, 1'b1);
      step_a(1'b0, 1'b1);
      step_a(1'b0, 1'b1);
      step_a(1'b1, 1'b1);
    end
    chk("sparse_ce_x", 32'(a_if.o_X_COORD), 32'd5);
    chk("sparse_ce_y", 32'(a_if.o_Y_COORD), 32'd1);

    // EN dropped mid-frame: frame completes, then IDLE.
    for (int i = 0; i < 99; i++) step_a(1'b1, 1'b0);
    chk("stop_last_running", 32'(a_if.o_RUNNING), 32'd1);
    chk("stop_last_x", 32'(a_if.o_X_COORD), 32'd14);
    step_a(1'b1, 1'b0);
    chk("stop_running", 32'(a_if.o_RUNNING), 32'd0);
    chk("stop_flags", 32'(a_flags()), 32'(7'b1101100));
    chk("stop_hold_y", 32'(a_if.o_Y_COORD), 32'd7);
    for (int i = 0; i < 3; i++) step_a(1'b1, 1'b0);

    // Restart: CE=0 keeps IDLE; next CE gives (0,0), count unchanged.
    step_a(1'b0, 1'b1);
    chk("restart_wait_running", 32'(a_if.o_RUNNING), 32'd0);
    step_a(1'b1, 1'b1);
    chk("restart_frame_start", 32'(a_if.o_FRAME_START), 32'd1);
    chk("restart_frame_cnt", 32'(a_if.o_FRAME_CNT), 32'd1);

    // Reset mid-frame with CE=0.
    for (int i = 0; i < 51; i++) step_a(1'b1, 1'b1);
    chk("pre_rst_x", 32'(a_if.o_X_COORD), 32'd6);
    rst_a = 1'b1;
    step_a(1'b0, 1'b1);
    chk("midrst_x", 32'(a_if.o_X_COORD), 32'd0);
    chk("midrst_cnt", 32'(a_if.o_FRAME_CNT), 32'd0);
    chk("midrst_flags", 32'(a_flags()), 32'(7'b1101100));
    rst_a = 1'b0;

    // Frame counter wraps modulo 2^3 after eight frames.
    step_a(1'b1, 1'b1);
    for (int i = 0; i < 8 * AHT * AVT; i++) step_a(1'b1, 1'b1);
    chk("cnt_wrap", 32'(a_if.o_FRAME_CNT), 32'd0);
    chk("cnt_wrap_frame_start", 32'(a_if.o_FRAME_START), 32'd1);

    // Instance B: active-high syncs.
    step_b();
    chk("b_rst_hsync", 32'(b_if.o_HSYNC), 32'd0);
    chk("b_rst_vsync", 32'(b_if.o_VSYNC), 32'd0);
    rst_b = 1'b0;
    hs_high = 0; vs_high = 0;
    for (int k = 0; k < BHT * BVT; k++) begin
      step_b();
      h = k % BHT;
      v = k / BHT;
      chk("b_x", 32'(b_if.o_X_COORD), 32'(h));
      chk("b_y", 32'(b_if.o_Y_COORD), 32'(v));
      chk("b_flags", 32'(b_flags()), 32'(exp_flags(h, v, 1'b1, 6, 1, 2, 3, 1, 1, 1'b1)));
      if (b_if.o_HSYNC) hs_high++;
      if (b_if.o_VSYNC) vs_high++;
      if (k == 7) chk("b_hsync_at_7", 32'(b_if.o_HSYNC), 32'd1);
      if (k == 40) chk("b_vsync_at_v4", 32'(b_if.o_VSYNC), 32'd1);
    end
    chk("b_hsync_high_per_frame", 32'(hs_high), 32'd12);
    chk("b_vsync_high_per_frame", 32'(vs_high), 32'd10);
    step_b();
    chk("b_wrap_cnt", 32'(b_if.o_FRAME_CNT), 32'd1);
    chk("b_wrap_frame_start", 32'(b_if.o_FRAME_START), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
